// File: rtl/dctq_pkg.sv
// rtl/dctq_pkg.sv - shared constants and row tag type for the row gather / adder tree path
package dctq_pkg;
  localparam int DW       = 14;
  localparam int NUM_TAPS = 8;
  localparam int ADD_LAT  = 5;
  localparam int SUM_W    = 17;
  localparam int TAG_W    = 3;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } row_tag_t;
endpackage

// File: rtl/row_gather8_valid_delay.sv
// rtl/row_gather8_valid_delay.sv - LAT-stage shift register carrying {valid, row tag}
module valid_delay
  import dctq_pkg::*;
#(
  parameter int LAT = ADD_LAT
) (
  input  logic     clk,
  input  logic     rst,
  input  row_tag_t tag_i,
  output row_tag_t tag_o
);

  row_tag_t pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/row_gather8.sv
// rtl/row_gather8.sv - gathers eight serial samples into parallel adder operands with tagged sum-valid
module row_gather8 #(
  parameter int DW      = dctq_pkg::DW,
  parameter int ADD_LAT = dctq_pkg::ADD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          hold,
  output logic [DW-1:0] n0,
  output logic [DW-1:0] n1,
  output logic [DW-1:0] n2,
  output logic [DW-1:0] n3,
  output logic [DW-1:0] n4,
  output logic [DW-1:0] n5,
  output logic [DW-1:0] n6,
  output logic [DW-1:0] n7,
  output logic          row_valid,
  output logic          sum_valid,
  output logic [2:0]    row_idx,
  output logic          block_done
);
  import dctq_pkg::row_tag_t;
  import dctq_pkg::TAG_W;

  logic [2:0]       wcnt_q;
  logic [DW-1:0]    gath_q [8];
  logic [DW-1:0]    n_q    [8];
  logic             row_valid_q;
  logic [TAG_W-1:0] row_cnt_q;
  logic             accept;
  row_tag_t         row_tag_d;
  row_tag_t         sum_tag;

  assign din_ready = ~hold & ~rst;
  assign accept    = din_valid & din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q      <= '0;
      row_valid_q <= 1'b0;
      row_cnt_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        gath_q[i] <= '0;
        n_q[i]    <= '0;
      end
    end else begin
      row_valid_q <= 1'b0;
      // The tag is sampled into the delay line during the row_valid cycle, then advances.
      if (row_valid_q) row_cnt_q <= row_cnt_q + 3'd1;
      if (accept) begin
        wcnt_q <= wcnt_q + 3'd1;
        if (wcnt_q == 3'd7) begin
          for (int i = 0; i < 7; i++) n_q[i] <= gath_q[i];
          n_q[7]      <= din;
          row_valid_q <= 1'b1;
        end else begin
          gath_q[wcnt_q] <= din;
        end
      end
    end
  end

  always_comb begin
    row_tag_d     = '0;
    row_tag_d.vld = row_valid_q;
    row_tag_d.tag = row_cnt_q;
  end

  valid_delay #(.LAT(ADD_LAT)) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .tag_i (row_tag_d),
    .tag_o (sum_tag)
  );

  assign n0 = n_q[0];
  assign n1 = n_q[1];
  assign n2 = n_q[2];
  assign n3 = n_q[3];
  assign n4 = n_q[4];
  assign n5 = n_q[5];
  assign n6 = n_q[6];
  assign n7 = n_q[7];

  assign row_valid  = row_valid_q;
  assign sum_valid  = sum_tag.vld;
  assign row_idx    = sum_tag.tag;
  assign block_done = sum_tag.vld & (sum_tag.tag == 3'd7);

endmodule

// File: tb/tb_row_gather8.sv
// tb/tb_row_gather8.sv - randomized and directed bench for row_gather8 against a queue-based row model
module tb_row_gather8;
  localparam int DW  = 14;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst, din_valid, hold;
  logic [DW-1:0] din;
  logic          din_ready, row_valid, sum_valid, block_done;
  logic [2:0]    row_idx;
  logic [DW-1:0] n0, n1, n2, n3, n4, n5, n6, n7;

  row_gather8 #(.DW(DW), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .hold(hold), .n0(n0), .n1(n1), .n2(n2), .n3(n3), .n4(n4), .n5(n5), .n6(n6), .n7(n7),
    .row_valid(row_valid), .sum_valid(sum_valid), .row_idx(row_idx), .block_done(block_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int tag; int sum; } pend_t;

  int    checks = 0, errors = 0, cyc = 0;
  int    done_cnt = 0, sv_cnt = 0, row_num = 0;
  int    rowq[$];
  pend_t pend[$];
  int    exp_n[8];
  bit    exp_rv = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the row model at the edge, compare 1ns after it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic h, input logic r);
    logic [DW-1:0] nv[8];
    pend_t         e;
    bit            exp_sv;
    int            s, obs_sum;
    din_valid = v; din = d; hold = h; rst = r;
    #1;
    chk("din_ready", {63'd0, din_ready}, {63'd0, (!h && !r)});
    @(posedge clk);
    cyc++;
    if (r) begin
      rowq.delete(); pend.delete(); row_num = 0; exp_rv = 1'b0;
      for (int i = 0; i < 8; i++) exp_n[i] = 0;
    end else begin
      exp_rv = 1'b0;
      if (v && !h) begin
        rowq.push_back(int'($signed(d)));
        if (rowq.size() == 8) begin
          s = 0;
          for (int i = 0; i < 8; i++) begin exp_n[i] = rowq[i]; s += rowq[i]; end
          pend.push_back('{cyc + LAT, row_num, s});
          row_num = (row_num + 1) % 8;
          exp_rv  = 1'b1;
          rowq.delete();
        end
      end
    end
    exp_sv = 1'b0;
    e = '{0, 0, 0};
    if (!r && pend.size() > 0 && pend[0].due == cyc) begin
      exp_sv = 1'b1;
      e = pend.pop_front();
    end
    #1;
    nv[0] = n0; nv[1] = n1; nv[2] = n2; nv[3] = n3; nv[4] = n4; nv[5] = n5; nv[6] = n6; nv[7] = n7;
    chk("row_valid", {63'd0, row_valid}, {63'd0, exp_rv});
    chk("sum_valid", {63'd0, sum_valid}, {63'd0, exp_sv});
    chk("block_done", {63'd0, block_done}, {63'd0, (exp_sv && e.tag == 7)});
    for (int i = 0; i < 8; i++) begin
      s = exp_n[i];
      chk($sformatf("n%0d", i), {50'd0, nv[i]}, {50'd0, s[DW-1:0]});
    end
    if (exp_sv) begin
      obs_sum = 0;
      for (int i = 0; i < 8; i++) obs_sum += int'($signed(nv[i]));
      chk("row_idx", {61'd0, row_idx}, 64'(e.tag));
      chk("adder_sum", 64'(obs_sum), 64'(e.sum));
    end
    if (r) chk("row_idx_rst", {61'd0, row_idx}, 64'd0);
    if (sum_valid) sv_cnt++;
    if (block_done) done_cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input int v);
    step(1'b1, DW'(v), 1'b0, 1'b0);
  endtask

  initial begin
    int base, acc;
    logic v;
    rst = 1'b1; din_valid = 1'b0; hold = 1'b0; din = '0;
    @(negedge clk);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Row 1..8, sum 36, tag 0
    base = sv_cnt;
    for (int i = 1; i <= 8; i++) push(i);
    idle(7);
    chk("sv_count_first_row", 64'(sv_cnt - base), 64'd1);

    // Eight rows of -8192, one block_done
    step(1'b0, '0, 1'b0, 1'b1);
    base = done_cnt;
    for (int i = 0; i < 64; i++) push(32'h2000);
    idle(7);
    chk("block_done_once", 64'(done_cnt - base), 64'd1);

    // Hold for 4 cycles after the 3rd sample
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) push(100 + i);
    for (int i = 0; i < 4; i++) step(1'b1, DW'(999), 1'b1, 1'b0);
    for (int i = 4; i <= 8; i++) push(100 + i);
    idle(7);

    // Reset mid-row, then a fresh row 10..17
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) push(50 + i);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 10; i <= 17; i++) push(i);
    idle(7);

    // Reset two cycles after row_valid kills the in-flight sum
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push(i - 4);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b1);
    base = sv_cnt;
    idle(6);
    chk("no_sum_after_rst", 64'(sv_cnt - base), 64'd0);

    // Random data with random din_valid gaps
    step(1'b0, '0, 1'b0, 1'b1);
    base = sv_cnt;
    acc = 0;
    while (acc < 48) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, DW'($urandom), 1'b0, 1'b0);
      if (v) acc++;
    end
    idle(7);
    chk("sv_count_gaps", 64'(sv_cnt - base), 64'd6);

    // Random data with random gaps and holds
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
    idle(7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_gather8.md
ROW_GATHER8 -- requirements
Module: row_gather8

Interface
REQ-001 Parameter DW, default 14, width of each input sample and of each of the eight operand outputs.
REQ-002 Parameter ADD_LAT, default 5, clock latency of the downstream eight-input adder tree, from operands applied to sum valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  DW  signed two's-complement sample, serial row order.
REQ-006 din_valid  input  1  din holds a sample this cycle.
REQ-007 din_ready  output  1  block accepts din this cycle; equals ~hold.
REQ-008 hold  input  1  upstream stall request; blocks acceptance.
REQ-009 n0..n7  output  DW each  parallel operands to the adder; n0 = first sample of the row.
REQ-010 row_valid  output  1  one-cycle pulse: n0..n7 updated with a new complete row this cycle.
REQ-011 sum_valid  output  1  one-cycle pulse: adder sum for the row is valid this cycle.
REQ-012 row_idx  output  3  index 0..7 of the row whose sum is flagged by sum_valid.
REQ-013 block_done  output  1  one-cycle pulse, coincident with sum_valid for row_idx = 7.

Function
REQ-014 A sample is accepted on a rising edge only when din_valid = 1 and din_ready = 1.
REQ-015 Accepted samples fill an 8-entry gather register at write slot wcnt (0..7); wcnt increments on each accept and wraps 7 -> 0.
REQ-016 On the edge accepting slot 7, n0..n7 load all eight samples: slots 0..6 from the gather register, slot 7 from din directly. row_valid = 1 in the following cycle.
REQ-017 n0..n7 hold their values until the next completed row; the gather register refills concurrently, so back-to-back rows need no idle cycles.
REQ-018 Minimum row period is 8 cycles; n0..n7 stay stable at least 8 cycles, exceeding ADD_LAT.
REQ-019 sum_valid is row_valid delayed exactly ADD_LAT cycles: row_valid in cycle T gives sum_valid in cycle T+5.
REQ-020 A row counter (0..7) advances on each row_valid; its value tags the row and travels through the delay line to appear on row_idx with sum_valid; it wraps 7 -> 0.
REQ-021 block_done = sum_valid AND row_idx = 7.
REQ-022 hold = 1 forces din_ready = 0; wcnt, the gather register and n0..n7 are frozen. The delay line keeps running so in-flight sums still emerge.
REQ-023 din_valid = 0 with hold = 0: no accept, state unchanged except the delay line.
REQ-024 Samples pass unmodified, no sign or width change. The output sum width (DW+3) is the adder's concern.

Reset
REQ-025 While rst = 1 at a rising edge: wcnt = 0, row counter = 0, gather register and n0..n7 = 0, row_valid = 0, delay line cleared, sum_valid = 0, row_idx = 0, block_done = 0.
REQ-026 Reset mid-row discards the partial row; the first accept after reset goes to slot 0.
REQ-027 Reset while rows are in flight: no sum_valid emerges for pre-reset rows.
REQ-028 din_ready = 0 while rst = 1.

Structure
REQ-029 Shared package dctq_pkg holds DW = 14, NUM_TAPS = 8, ADD_LAT = 5 and SUM_W = 17, shared with the adder tree.
REQ-030 One sub-module, valid_delay, is a parameterised ADD_LAT-stage shift register that carries {valid, 3-bit row tag}, with synchronous reset.

Verification
REQ-031 Stream samples 1..8 back-to-back after reset -> row_valid in the cycle after the 8th accept, n0..n7 = 1..8; sum_valid 5 cycles later with row_idx = 0; attached adder sum = 36.
REQ-032 Eight rows, each of eight copies of 14'h2000 (-8192), continuous -> row_valid every 8 cycles, row_idx runs 0..7, block_done once, adder sum = -65536 on every row.
REQ-033 Assert hold for 4 cycles after the 3rd sample -> din_ready = 0 for those cycles, no accept; remaining 5 samples complete the row with n0..n7 in correct order.
REQ-034 Assert rst after the 5th sample, then stream 8 new samples 10..17 -> n0..n7 = 10..17 and no stale values; row_idx = 0.
REQ-035 Assert rst two cycles after a row_valid -> no sum_valid in the following 5 cycles.
REQ-036 Insert random din_valid gaps while hold = 0 -> sample order and row_idx sequence match the gapless run, and each sum_valid occurs exactly 5 cycles after its row_valid.
